// File: rtl/rdc_ctrl.sv
// rdc_ctrl: sequencing controller for the Request Duration Counter.
// Owns the per-event weight registers, drives the RDC enable and its
// synchronous active-low reset, and turns an RDC interrupt into a scanned,
// acknowledged offence report for software.
//
// Handshake: start_i, stop_i and ack_i are single-cycle pulses sampled on
// the rising clock edge; they only act in the states listed below and are
// otherwise ignored. cfg_we_i is likewise a one-cycle strobe sampled on the
// edge; a write is accepted only in IDLE with an in-range index.
module rdc_ctrl #(
  parameter  int WEIGHTS_WIDTH  = 8,
  parameter  int N_CORES        = 4,
  parameter  int CORE_EVENTS    = 2,
  parameter  int TRIP_CNT_WIDTH = 16,
  localparam int N_COUNTERS     = N_CORES * CORE_EVENTS,
  localparam int IDX_W          = $clog2(N_COUNTERS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cfg_we_i,
  input  logic [IDX_W-1:0]                    cfg_idx_i,
  input  logic [WEIGHTS_WIDTH-1:0]            cfg_weight_i,
  input  logic                                start_i,
  input  logic                                stop_i,
  input  logic                                ack_i,
  input  logic                                auto_rearm_i,
  input  logic                                rdc_irq_i,
  input  logic [N_COUNTERS-1:0]               rdc_vector_i,
  output logic                                rdc_enable_o,
  output logic                                rdc_rstn_o,
  output logic [N_COUNTERS*WEIGHTS_WIDTH-1:0] rdc_weights_o,
  output logic                                irq_o,
  output logic                                offender_valid_o,
  output logic [IDX_W-1:0]                    offender_idx_o,
  output logic [N_COUNTERS-1:0]               trip_vec_o,
  output logic [TRIP_CNT_WIDTH-1:0]           trip_count_o,
  output logic                                cfg_err_o,
  output logic [2:0]                          state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_ARMED  = 3'd2,
    S_SCAN   = 3'd3,
    S_REPORT = 3'd4
  } state_e;

  localparam logic [IDX_W:0]   N_CNT    = (IDX_W+1)'(N_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COUNTERS - 1);

  state_e                    state_q, state_d;
  logic                      rearm_q, rearm_d;   // CLR exits to ARMED when set
  logic                      capture;
  logic [IDX_W-1:0]          scan_q;
  logic                      scan_hit;
  logic                      in_range, wr_ok, wr_bad;
  logic [WEIGHTS_WIDTH-1:0]  weight_q [N_COUNTERS];

  assign state_o   = state_q;
  assign in_range  = ({1'b0, cfg_idx_i} < N_CNT);
  assign wr_ok     = cfg_we_i && (state_q == S_IDLE) && in_range;
  assign wr_bad    = cfg_we_i && !((state_q == S_IDLE) && in_range);
  // First set bit of the captured vector, only the first one counts.
  assign scan_hit  = (state_q == S_SCAN) && trip_vec_o[scan_q] && !offender_valid_o;

  // Next-state logic and CLR exit selection.
  always_comb begin
    state_d = state_q;
    rearm_d = rearm_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLR;
          rearm_d = 1'b1;
        end
      end
      S_CLR:   state_d = rearm_q ? S_ARMED : S_IDLE;
      S_ARMED: begin
        if (rdc_irq_i) begin
          state_d = S_SCAN;
          capture = 1'b1;
        end else if (stop_i) begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (scan_q == LAST_IDX) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (stop_i) begin
          state_d = S_CLR;
          rearm_d = 1'b0;
        end else if (ack_i) begin
          state_d = S_CLR;
          rearm_d = auto_rearm_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and scan position.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rearm_q <= 1'b0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      rearm_q <= rearm_d;
      if (capture)               scan_q <= '0;
      else if (state_q == S_SCAN) scan_q <= scan_q + IDX_W'(1);
    end
  end

  // RDC control outputs, registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdc_enable_o <= 1'b0;
      rdc_rstn_o   <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      rdc_enable_o <= (state_d == S_ARMED);
      rdc_rstn_o   <= (state_d != S_CLR);
      irq_o        <= (state_d == S_REPORT);
    end
  end

  // Capture, trip counting and offender search results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trip_vec_o       <= '0;
      trip_count_o     <= '0;
      offender_valid_o <= 1'b0;
      offender_idx_o   <= '0;
    end else begin
      if (capture) begin
        trip_vec_o       <= rdc_vector_i;
        offender_valid_o <= 1'b0;
        offender_idx_o   <= '0;
        if (trip_count_o != {TRIP_CNT_WIDTH{1'b1}})
          trip_count_o <= trip_count_o + TRIP_CNT_WIDTH'(1);
      end else if (state_d == S_CLR) begin
        offender_valid_o <= 1'b0;
      end else if (scan_hit) begin
        offender_valid_o <= 1'b1;
        offender_idx_o   <= scan_q;
      end
    end
  end

  // Weight registers and the sticky configuration error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_COUNTERS; k++) weight_q[k] <= '1;
      cfg_err_o <= 1'b0;
    end else begin
      if (wr_ok) weight_q[cfg_idx_i] <= cfg_weight_i;
      if ((state_q == S_IDLE) && start_i) cfg_err_o <= 1'b0;
      if (wr_bad) cfg_err_o <= 1'b1;
    end
  end

  // Flatten the weight array onto the RDC bus.
  always_comb begin
    rdc_weights_o = '0;
    for (int k = 0; k < N_COUNTERS; k++)
      rdc_weights_o[k*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] = weight_q[k];
  end

endmodule
